// File: rtl/audio_mix_n.sv
// Time-multiplexed N-source stereo mixer: one shared multiplier/accumulator,
// per-frame volume ramping, saturating signed output and sticky overflow flag.
module audio_mix_n #(
  parameter int NUM_INPUTS = 5,
  parameter int IN_WIDTH   = 16,
  parameter int VOL_WIDTH  = 8,
  parameter int RAMP_STEP  = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             sample_strobe,
  input  logic                             swap_channels,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0]   audio_in_l,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0]   audio_in_r,
  input  logic [NUM_INPUTS*VOL_WIDTH-1:0]  audio_vol,
  input  logic                             overflow_clr,
  output logic [IN_WIDTH+VOL_WIDTH-1:0]    audio_l,
  output logic [IN_WIDTH+VOL_WIDTH-1:0]    audio_r,
  output logic                             audio_valid,
  output logic                             audio_overflow,
  output logic                             busy
);

  localparam int OUT_W  = IN_WIDTH + VOL_WIDTH;
  localparam int PROD_W = OUT_W + 2;
  localparam int ACC_W  = PROD_W + $clog2(NUM_INPUTS);
  localparam int IDX_W  = $clog2(NUM_INPUTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_INPUTS - 1);

  typedef enum logic [2:0] {IDLE, LEFT, LDRAIN, RIGHT, RDRAIN, OUT} state_t;

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [VOL_WIDTH-1:0]       cur_vol  [NUM_INPUTS];
  logic [VOL_WIDTH-1:0]       next_vol [NUM_INPUTS];
  logic                       swap_q;
  logic                       prod_vld;
  logic signed [PROD_W-1:0]   prod, prod_next, samp_ext, gain_ext;
  logic signed [ACC_W-1:0]    acc, sum;
  logic [ACC_W-OUT_W:0]       hi_bits;
  logic [OUT_W-1:0]           sat_l, sat_r, sat_sum;
  logic                       ovf_l, ovf_r, ovf_sum;
  logic [IN_WIDTH-1:0]        samp;
  logic [VOL_WIDTH-1:0]       vol_sel;

  assign busy = (state != IDLE);

  // Effective volume moves toward the target by at most RAMP_STEP per frame.
  always_comb begin
    int tgt, cur, nv;
    tgt = 0;
    cur = 0;
    nv  = 0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      tgt = int'(audio_vol[i*VOL_WIDTH +: VOL_WIDTH]);
      cur = int'(cur_vol[i]);
      if (RAMP_STEP == 0)
        nv = tgt;
      else if (tgt > cur)
        nv = (tgt - cur > RAMP_STEP) ? cur + RAMP_STEP : tgt;
      else
        nv = (cur - tgt > RAMP_STEP) ? cur - RAMP_STEP : tgt;
      next_vol[i] = VOL_WIDTH'(nv);
    end
  end

  always_comb begin
    samp      = (state == RIGHT) ? audio_in_r[idx*IN_WIDTH +: IN_WIDTH]
                                 : audio_in_l[idx*IN_WIDTH +: IN_WIDTH];
    vol_sel   = cur_vol[idx];
    samp_ext  = {{(PROD_W-IN_WIDTH){samp[IN_WIDTH-1]}}, samp};
    gain_ext  = {{IN_WIDTH{1'b0}}, 1'b0, vol_sel, 1'b0};
    prod_next = samp_ext * gain_ext;
    sum       = prod_vld ? acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : acc;
    // Sum fits OUT_W iff every bit from the OUT_W sign bit upward agrees.
    hi_bits   = sum[ACC_W-1:OUT_W-1];
    ovf_sum   = !((&hi_bits) || !(|hi_bits));
    if (!ovf_sum)
      sat_sum = sum[OUT_W-1:0];
    else if (sum[ACC_W-1])
      sat_sum = {1'b1, {(OUT_W-1){1'b0}}};
    else
      sat_sum = {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      swap_q         <= 1'b0;
      prod_vld       <= 1'b0;
      prod           <= '0;
      acc            <= '0;
      sat_l          <= '0;
      sat_r          <= '0;
      ovf_l          <= 1'b0;
      ovf_r          <= 1'b0;
      audio_l        <= '0;
      audio_r        <= '0;
      audio_valid    <= 1'b0;
      audio_overflow <= 1'b0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) cur_vol[i] <= '0;
    end else begin
      audio_valid <= 1'b0;
      prod_vld    <= (state == LEFT) || (state == RIGHT);
      acc         <= sum;
      if (overflow_clr) audio_overflow <= 1'b0;
      case (state)
        IDLE: if (sample_strobe) begin
          state   <= LEFT;
          idx     <= '0;
          acc     <= '0;
          swap_q  <= swap_channels;
          cur_vol <= next_vol;
        end
        LEFT, RIGHT: begin
          prod <= prod_next;
          if (idx == LAST) begin
            idx   <= '0;
            state <= (state == LEFT) ? LDRAIN : RDRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        LDRAIN: begin
          sat_l <= sat_sum;
          ovf_l <= ovf_sum;
          acc   <= '0;
          state <= RIGHT;
        end
        RDRAIN: begin
          sat_r <= sat_sum;
          ovf_r <= ovf_sum;
          state <= OUT;
        end
        OUT: begin
          audio_l     <= swap_q ? sat_r : sat_l;
          audio_r     <= swap_q ? sat_l : sat_r;
          audio_valid <= 1'b1;
          if (ovf_l || ovf_r) audio_overflow <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
